// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, with an
// IDLE/RUN/DONE controller and registered sum/carry-out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request sampled only in IDLE (a/b captured on that
  // edge); done is a one-cycle pulse during which sum/cout hold the new result.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Full adder from two half-adder stages plus an OR of their carries.
  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
  assign ha1_s = opa_q[0] ^ opb_q[0];
  assign ha1_c = opa_q[0] & opb_q[0];
  assign ha2_s = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;
  assign fa_c  = ha1_c | ha2_c;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {ha2_s, res_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {ha2_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign state_dbg = state_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to add a and b; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 busy  output  1  high while an addition is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse; sum/cout valid and complete.
REQ-009 sum  output  WIDTH  registered result, a+b modulo 2^WIDTH.
REQ-010 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-011 Block SHALL add bit-serially, LSB first: one full-adder bit per clock, built from two half-adder stages (s = x^y, c = x&y) plus an OR of the two carries.
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL capture a and b into operand shift registers, clear the carry flop, clear the bit counter to 0, and move to RUN.
REQ-014 IDLE: start=0 SHALL leave all state unchanged.
REQ-015 RUN: each edge SHALL compute the bit from operand LSBs and the carry flop, shift the result bit into the MSB of an internal result shift register, shift both operands right by one, update the carry flop, and increment the counter.
REQ-016 RUN: on the edge that processes bit WIDTH-1, the block SHALL load sum from the completed result register and cout from the final carry, and move to DONE.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH, and low in every other cycle.
REQ-019 busy SHALL be high exactly in RUN cycles (WIDTH cycles per operation) and low in IDLE and DONE.
REQ-020 start SHALL be ignored in RUN and DONE; operands SHALL NOT change mid-operation.
REQ-021 sum and cout SHALL hold the previous result throughout RUN and IDLE, changing only on the REQ-016 edge.
REQ-022 Back-to-back: start held high continuously SHALL start a new operation every WIDTH+2 cycles (IDLE accept, WIDTH RUN, DONE).
REQ-023 Overflow SHALL wrap: sum = (a+b) mod 2^WIDTH and cout = bit WIDTH of a+b.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, operand and result registers=0.
REQ-026 rst SHALL override start and any in-flight operation; an aborted operation SHALL produce no done pulse and no change to sum/cout other than the clear.
REQ-027 The first edge with rst=0 SHALL leave the block in IDLE, ready to accept start.

Verification
REQ-028 WIDTH=8, a=0x00, b=0x00, start 1 cycle -> busy high 8 cycles, done pulse 8 cycles after the accept edge, sum=0x00, cout=0.
REQ-029 WIDTH=8, a=0xA5, b=0x5A -> sum=0xFF, cout=0; a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple).
REQ-030 WIDTH=8, a=0x12, b=0x34 accepted, then start pulsed with a=0xFF, b=0xFF during RUN -> ignored, result sum=0x46, cout=0, single done pulse.
REQ-031 WIDTH=8, a=0x80, b=0x80 accepted, rst asserted 3 cycles into RUN -> next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse follows.
REQ-032 WIDTH=4 instance, a=0xF, b=0xF -> sum=0xE, cout=1, done 4 cycles after accept; with start held high, next accept exactly 6 cycles after previous one.
REQ-033 Randomised check: 1000 random a/b at WIDTH=8 against a reference a+b model; sum/cout compared at every done pulse.
